// File: rtl/uart_pkg.sv
// Shared UART definitions: default byte width and transmit sequencer state encoding.
package uart_pkg;

   localparam int UART_DATA_W = 8;

   typedef logic [1:0] state_t;

   // Sequencer states; plain constants so older code can compare against raw values.
   localparam state_t ST_IDLE   = 2'd0;
   localparam state_t ST_LAUNCH = 2'd1;
   localparam state_t ST_WAIT   = 2'd2;

endpackage

// File: rtl/uart_tx_queue_if.sv
// Byte push side and transmitter handshake of the transmit queue.
// master: the side that pushes bytes and reports tx_done (echo logic + transmitter).
// slave:  the queue itself.
interface uart_tx_queue_if
   import uart_pkg::*;
#(
   parameter int DATA_W = UART_DATA_W
) ();

   logic              push;
   logic [DATA_W-1:0] push_data;
   logic              tx_done;
   logic              tx_start;
   logic [DATA_W-1:0] tx_data;

   modport master (
      output push, push_data, tx_done,
      input  tx_start, tx_data
   );

   modport slave (
      input  push, push_data, tx_done,
      output tx_start, tx_data
   );

endinterface

// File: rtl/uart_sync_fifo.sv
// Circular byte buffer with a separate occupancy counter.
// Writes are refused when full unless a read happens in the same cycle.
// rd_data always shows the oldest entry; the reader registers it on pop.
module uart_sync_fifo
   import uart_pkg::*;
#(
   parameter int DATA_W = UART_DATA_W,
   parameter int DEPTH  = 16,
   parameter int ADDR_W = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              wr_en,
   input  logic [DATA_W-1:0] wr_data,
   input  logic              rd_en,
   output logic [DATA_W-1:0] rd_data,
   output logic [ADDR_W:0]   count,
   output logic              full,
   output logic              empty
);

   logic [DATA_W-1:0] mem [DEPTH];
   logic [ADDR_W-1:0] wr_ptr_reg;
   logic [ADDR_W-1:0] rd_ptr_reg;
   logic [ADDR_W:0]   count_reg;
   logic              wr_ok;
   logic              rd_ok;

   assign rd_ok   = rd_en && !empty;
   assign wr_ok   = wr_en && (!full || rd_ok);
   assign rd_data = mem[rd_ptr_reg];
   assign count   = count_reg;
   assign full    = (count_reg == (ADDR_W+1)'(DEPTH));
   assign empty   = (count_reg == '0);

   // Storage array carries no reset so it maps onto RAM.
   always_ff @(posedge clk) begin
      if (wr_ok) mem[wr_ptr_reg] <= wr_data;
   end

   // Pointers wrap naturally because DEPTH is a power of two; count tracks occupancy.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         count_reg  <= '0;
      end else begin
         if (wr_ok) wr_ptr_reg <= wr_ptr_reg + 1'b1;
         if (rd_ok) rd_ptr_reg <= rd_ptr_reg + 1'b1;
         case ({wr_ok, rd_ok})
            2'b10:   count_reg <= count_reg + 1'b1;
            2'b01:   count_reg <= count_reg - 1'b1;
            default: count_reg <= count_reg;
         endcase
      end
   end

endmodule

// File: rtl/uart_tx_queue.sv
// Transmit queue: buffers pushed bytes and feeds them to the UART transmitter
// one at a time, waiting for tx_done (or a timeout) between bytes.
module uart_tx_queue
   import uart_pkg::*;
#(
   parameter int DATA_W  = UART_DATA_W,
   parameter int DEPTH   = 16,
   parameter int ADDR_W  = 4,
   parameter int TIMEOUT = 200000
) (
   input  logic            clk,
   input  logic            reset,
   uart_tx_queue_if.slave  bus,
   input  logic            clr_err,
   output logic [ADDR_W:0] count,
   output logic            full,
   output logic            empty,
   output logic            busy,
   output logic            overflow,
   output logic            timeout
);

   // Timer only needs to reach TIMEOUT-1.
   localparam int TIMER_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

   state_t              state_reg;
   logic [TIMER_W-1:0]  timer_reg;
   logic                tx_start_reg;
   logic [DATA_W-1:0]   tx_data_reg;
   logic                overflow_reg;
   logic                timeout_reg;
   logic [DATA_W-1:0]   rd_data;
   logic                pop;
   logic                wr_en;
   logic                timer_hit;

   // Pop only from IDLE; a push into an empty queue is seen by the FSM one cycle later.
   assign pop   = (state_reg == ST_IDLE) && !empty;
   assign wr_en = bus.push && (!full || pop);

   generate
      if (TIMEOUT == 0) begin : g_no_timeout
         assign timer_hit = 1'b0;
      end else begin : g_timeout
         assign timer_hit = (timer_reg == TIMER_W'(TIMEOUT - 1));
      end
   endgenerate

   uart_sync_fifo #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH),
      .ADDR_W (ADDR_W)
   ) u_fifo (
      .clk     (clk),
      .reset   (reset),
      .wr_en   (wr_en),
      .wr_data (bus.push_data),
      .rd_en   (pop),
      .rd_data (rd_data),
      .count   (count),
      .full    (full),
      .empty   (empty)
   );

   // Sequencer: launch one byte, hold tx_data, wait for tx_done or give up after the timeout.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_reg    <= ST_IDLE;
         timer_reg    <= '0;
         tx_start_reg <= 1'b0;
         tx_data_reg  <= '0;
      end else begin
         case (state_reg)
            ST_IDLE: begin
               if (pop) begin
                  tx_data_reg  <= rd_data;
                  tx_start_reg <= 1'b1;
                  state_reg    <= ST_LAUNCH;
               end
            end
            ST_LAUNCH: begin
               tx_start_reg <= 1'b0;
               timer_reg    <= '0;
               state_reg    <= ST_WAIT;
            end
            ST_WAIT: begin
               if (bus.tx_done || timer_hit) state_reg <= ST_IDLE;
               else                          timer_reg <= timer_reg + 1'b1;
            end
            default: begin
               tx_start_reg <= 1'b0;
               state_reg    <= ST_IDLE;
            end
         endcase
      end
   end

   // Sticky error flags; a clear in the same cycle as a new event wins.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         overflow_reg <= 1'b0;
         timeout_reg  <= 1'b0;
      end else if (clr_err) begin
         overflow_reg <= 1'b0;
         timeout_reg  <= 1'b0;
      end else begin
         if (bus.push && !wr_en) overflow_reg <= 1'b1;
         if (state_reg == ST_WAIT && !bus.tx_done && timer_hit) timeout_reg <= 1'b1;
      end
   end

   assign bus.tx_start = tx_start_reg;
   assign bus.tx_data  = tx_data_reg;
   assign busy         = (state_reg != ST_IDLE);
   assign overflow     = overflow_reg;
   assign timeout      = timeout_reg;

endmodule

// File: tb/tb_uart_tx_queue.sv
// Directed bench for uart_tx_queue. u0 uses the default timeout, u1 a short one.
// Expected bytes are queued when pushed and compared whenever a DUT issues tx_start.
module tb_uart_tx_queue;

   logic clk = 1'b0;
   logic reset;
   logic clr_err;

   logic [4:0] count0, count1;
   logic full0, empty0, busy0, overflow0, timeout0;
   logic full1, empty1, busy1, overflow1, timeout1;

   int errors = 0;
   int checks = 0;
   int start_cnt0 = 0;
   int start_cnt1 = 0;
   logic [7:0] exp0[$];
   logic [7:0] exp1[$];

   uart_tx_queue_if #(.DATA_W(8)) q0 ();
   uart_tx_queue_if #(.DATA_W(8)) q1 ();

   uart_tx_queue #(.DATA_W(8), .DEPTH(16), .ADDR_W(4), .TIMEOUT(200000)) u0 (
      .clk(clk), .reset(reset), .bus(q0.slave), .clr_err(clr_err),
      .count(count0), .full(full0), .empty(empty0), .busy(busy0),
      .overflow(overflow0), .timeout(timeout0)
   );

   uart_tx_queue #(.DATA_W(8), .DEPTH(16), .ADDR_W(4), .TIMEOUT(50)) u1 (
      .clk(clk), .reset(reset), .bus(q1.slave), .clr_err(clr_err),
      .count(count1), .full(full1), .empty(empty1), .busy(busy1),
      .overflow(overflow1), .timeout(timeout1)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   // Scoreboard: every tx_start must carry the oldest outstanding pushed byte.
   always @(negedge clk) begin
      if (q0.tx_start) begin
         start_cnt0++;
         check("u0_sb_pending", 32'(exp0.size() != 0), 1);
         if (exp0.size() != 0) check("u0_tx_data", q0.tx_data, exp0.pop_front());
      end
      if (q1.tx_start) begin
         start_cnt1++;
         check("u1_sb_pending", 32'(exp1.size() != 0), 1);
         if (exp1.size() != 0) check("u1_tx_data", q1.tx_data, exp1.pop_front());
      end
   end

   task automatic wait_start(input int which, output int lat);
      logic s;
      lat = 0;
      s = (which == 0) ? q0.tx_start : q1.tx_start;
      while (!s && lat < 400) begin
         @(negedge clk);
         lat++;
         s = (which == 0) ? q0.tx_start : q1.tx_start;
      end
      if (which == 0) check("u0_start_seen", s, 1);
      else            check("u1_start_seen", s, 1);
   endtask

   task automatic pulse_done(input int which);
      @(negedge clk);
      if (which == 0) q0.tx_done = 1'b1; else q1.tx_done = 1'b1;
      @(negedge clk);
      q0.tx_done = 1'b0;
      q1.tx_done = 1'b0;
   endtask

   initial begin
      int lat;
      int sc;
      reset = 1'b1;
      clr_err = 1'b0;
      q0.push = 1'b0; q0.push_data = '0; q0.tx_done = 1'b0;
      q1.push = 1'b0; q1.push_data = '0; q1.tx_done = 1'b0;
      repeat (3) @(negedge clk);

      // Reset state
      check("rst_tx_start", q0.tx_start, 0);
      check("rst_tx_data", q0.tx_data, 0);
      check("rst_count", count0, 0);
      check("rst_empty", empty0, 1);
      check("rst_full", full0, 0);
      check("rst_busy", busy0, 0);
      check("rst_flags", {overflow0, timeout0, overflow1, timeout1}, 0);
      reset = 1'b0;

      // 1: single byte, start the cycle after the push, exactly one cycle long
      @(negedge clk);
      q0.push = 1'b1; q0.push_data = 8'h41; exp0.push_back(8'h41);
      @(negedge clk);
      q0.push = 1'b0;
      check("t1_no_bypass", q0.tx_start, 0);
      check("t1_count", count0, 1);
      @(negedge clk);
      check("t1_start", q0.tx_start, 1);
      check("t1_busy", busy0, 1);
      check("t1_empty_in_flight", empty0, 1);
      @(negedge clk);
      check("t1_start_one_cycle", q0.tx_start, 0);
      repeat (5) @(negedge clk);
      check("t1_busy_wait", busy0, 1);
      pulse_done(0);
      check("t1_idle", busy0, 0);
      check("t1_empty", empty0, 1);
      check("t1_starts", start_cnt0, 1);

      // 2: five back-to-back pushes, 100-cycle frames
      for (int i = 1; i <= 5; i++) begin
         @(negedge clk);
         q0.push = 1'b1; q0.push_data = 8'(i); exp0.push_back(8'(i));
      end
      @(negedge clk);
      q0.push = 1'b0;
      check("t2_first_start", start_cnt0, 2);
      for (int k = 0; k < 5; k++) begin
         if (k > 0) begin
            wait_start(0, lat);
            check("t2_restart_latency", lat, 1);
         end
         repeat (99) @(negedge clk);
         pulse_done(0);
      end
      repeat (3) @(negedge clk);
      check("t2_starts", start_cnt0, 6);
      check("t2_overflow", overflow0, 0);
      check("t2_idle", {busy0, empty0}, 2'b01);
      check("t2_sb_drained", exp0.size(), 0);
      check("t2_tx_data_held", q0.tx_data, 8'h05);

      // 3: fill past capacity with the transmitter stalled
      for (int i = 0; i < 18; i++) begin
         @(negedge clk);
         if (i == 16) check("t3_not_full_16", full0, 0);
         if (i == 17) begin
            check("t3_full_17", full0, 1);
            check("t3_no_ovf_yet", overflow0, 0);
         end
         q0.push = 1'b1; q0.push_data = 8'(8'h10 + i);
         if (i < 17) exp0.push_back(8'(8'h10 + i));
      end
      @(negedge clk);
      q0.push = 1'b0;
      check("t3_count", count0, 16);
      check("t3_full", full0, 1);
      check("t3_overflow", overflow0, 1);
      check("t3_starts", start_cnt0, 7);

      // 4: push into a full queue in the same cycle as a pop
      @(negedge clk);
      q0.tx_done = 1'b1;
      @(negedge clk);
      q0.tx_done = 1'b0;
      q0.push = 1'b1; q0.push_data = 8'hAA; exp0.push_back(8'hAA);
      @(negedge clk);
      q0.push = 1'b0;
      check("t4_pop_start", q0.tx_start, 1);
      check("t4_count", count0, 16);
      check("t4_full", full0, 1);
      check("t4_overflow", overflow0, 1);
      @(negedge clk);
      clr_err = 1'b1;
      @(negedge clk);
      clr_err = 1'b0;
      check("t4_clr_overflow", overflow0, 0);
      for (int k = 0; k < 16; k++) begin
         repeat (3) @(negedge clk);
         pulse_done(0);
         wait_start(0, lat);
         check("t4_drain_latency", lat, 1);
      end
      repeat (3) @(negedge clk);
      pulse_done(0);
      repeat (2) @(negedge clk);
      check("t4_starts", start_cnt0, 24);
      check("t4_idle", {busy0, empty0}, 2'b01);
      check("t4_sb_drained", exp0.size(), 0);

      // 5: timeout on u1 (TIMEOUT=50), next byte launches, clr_err clears and wins
      @(negedge clk);
      q1.push = 1'b1; q1.push_data = 8'hC1; exp1.push_back(8'hC1);
      @(negedge clk);
      q1.push_data = 8'hC2; exp1.push_back(8'hC2);
      @(negedge clk);
      q1.push = 1'b0;
      wait_start(1, lat);
      repeat (50) @(negedge clk);
      check("t5_no_early_timeout", timeout1, 0);
      check("t5_busy", busy1, 1);
      @(negedge clk);
      check("t5_timeout", timeout1, 1);
      wait_start(1, lat);
      check("t5_next_latency", lat, 1);
      clr_err = 1'b1;
      @(negedge clk);
      clr_err = 1'b0;
      check("t5_clr_timeout", timeout1, 0);
      repeat (48) @(negedge clk);
      check("t5_second_waiting", {busy1, timeout1}, 2'b10);
      @(negedge clk);
      clr_err = 1'b1;
      @(negedge clk);
      clr_err = 1'b0;
      check("t5_clr_priority", timeout1, 0);
      check("t5_abandoned_idle", busy1, 0);
      check("t5_starts", start_cnt1, 2);

      // 6: asynchronous reset during WAIT with three bytes queued
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         q0.push = 1'b1; q0.push_data = 8'(8'h60 + i); exp0.push_back(8'(8'h60 + i));
      end
      @(negedge clk);
      q0.push = 1'b0;
      repeat (5) @(negedge clk);
      check("t6_count_before", count0, 3);
      check("t6_busy_before", busy0, 1);
      sc = start_cnt0;
      #2 reset = 1'b1;
      #1;
      check("t6_rst_tx_start", q0.tx_start, 0);
      check("t6_rst_tx_data", q0.tx_data, 0);
      check("t6_rst_count", count0, 0);
      check("t6_rst_status", {full0, empty0, busy0, overflow0, timeout0}, 5'b01000);
      exp0.delete();
      exp1.delete();
      @(negedge clk);
      reset = 1'b0;
      pulse_done(0);
      repeat (10) @(negedge clk);
      check("t6_no_start_after_reset", start_cnt0, sc);
      check("t6_idle", {busy0, empty0}, 2'b01);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
